// File: rtl/matrix_op_scheduler.sv
// -----------------------------------------------------------------------------
// matrix_op_scheduler
//
// Command dispatcher in front of a bank of matrix operator units that share a
// single BRAM port. A command is accepted over a valid/ready handshake. It is
// then validated for opcode, dimensions and result address range. If it is
// valid, the selected unit is started with a level start/done handshake and
// that unit's memory bus is steered onto the BRAM port. The command finishes
// with a status response that carries an error code and the RUN cycle count.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op, cmd_m/n/p              opcode (unit index) and dimensions
//   cmd_addr_a/b/c                 operand and result base addresses
//   op_m/n/p, op_addr_a/b/c        latched command fields, broadcast to units
//   unit_start                     one-hot start level to the selected unit
//   unit_done                      per-unit done level
//   unit_rd_en/wr_en/rd_addr/wr_addr/wr_data
//                                  per-unit memory requests (flattened, unit k
//                                  occupies slice k)
//   mem_rd_en/wr_en/rd_addr/wr_addr/wr_data
//                                  shared BRAM port
//   busy                           high whenever the scheduler is not idle
//   resp_valid/resp_ready          response handshake
//   resp_err                       0 OK, 1 bad opcode, 2 bad dim/range,
//                                  3 timeout
//   resp_cycles                    cycles spent in RUN, saturating
// -----------------------------------------------------------------------------
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 16
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif

module matrix_op_scheduler #(
    parameter int NUM_UNITS      = 4,
    parameter int ELEMENT_WIDTH  = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH     = `BRAM_ADDR_WIDTH,
    parameter int MAX_DIM        = 5,
    parameter int MUL_OP         = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [3:0]                       cmd_m,
    input  logic [3:0]                       cmd_n,
    input  logic [3:0]                       cmd_p,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_b,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_c,
    output logic [3:0]                       op_m,
    output logic [3:0]                       op_n,
    output logic [3:0]                       op_p,
    output logic [ADDR_WIDTH-1:0]            op_addr_a,
    output logic [ADDR_WIDTH-1:0]            op_addr_b,
    output logic [ADDR_WIDTH-1:0]            op_addr_c,
    output logic [NUM_UNITS-1:0]             unit_start,
    input  logic [NUM_UNITS-1:0]             unit_done,
    input  logic [NUM_UNITS-1:0]             unit_rd_en,
    input  logic [NUM_UNITS-1:0]             unit_wr_en,
    input  logic [NUM_UNITS*ADDR_WIDTH-1:0]  unit_rd_addr,
    input  logic [NUM_UNITS*ADDR_WIDTH-1:0]  unit_wr_addr,
    input  logic [NUM_UNITS*ELEMENT_WIDTH-1:0] unit_wr_data,
    output logic                             mem_rd_en,
    output logic                             mem_wr_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0]         mem_wr_data,
    output logic                             busy,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [1:0]                       resp_err,
    output logic [15:0]                      resp_cycles
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam logic [3:0]  NUM_UNITS_L = 4'(NUM_UNITS);
    localparam logic [3:0]  MAX_DIM_L   = 4'(MAX_DIM);
    localparam logic [2:0]  MUL_OP_L    = 3'(MUL_OP);
    localparam logic [15:0] TIMEOUT_L   = 16'(TIMEOUT_CYCLES);
    // One past the last BRAM word: a result may end exactly here.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [3:0]            m_q, m_d, n_q, n_d, p_q, p_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            err_q, err_d;
    logic [15:0]           cycles_q, cycles_d;
    logic                  abort_q, abort_d;

    logic                  ready_q, busy_q, resp_valid_q, steer_q;
    logic [NUM_UNITS-1:0]  start_q, start_d;

    logic [NUM_UNITS-1:0]  sel_s;
    logic                  done_sel_s;
    logic [1:0]            chk_err_s;
    logic [7:0]            mn_s;
    logic [ADDR_WIDTH:0]   end_s;
    logic [15:0]           cnt_inc_s;
    logic                  timeout_s;

    // One-hot decode of the latched opcode; done bits of other units are masked off.
    always_comb begin
        sel_s = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sel_s[k] = (op_q == 3'(k));
        end
        done_sel_s = |(sel_s & unit_done);
    end

    // Command validation in priority order; the range check is one bit wider
    // than the address so that a result ending on the last word is legal.
    always_comb begin
        mn_s  = {4'd0, m_q} * {4'd0, n_q};
        end_s = {1'b0, addr_c_q} + (ADDR_WIDTH+1)'(mn_s);
        if ({1'b0, op_q} >= NUM_UNITS_L) begin
            chk_err_s = 2'd1;
        end else if ((m_q == 4'd0) || (m_q > MAX_DIM_L) || (n_q == 4'd0) || (n_q > MAX_DIM_L)) begin
            chk_err_s = 2'd2;
        end else if ((op_q == MUL_OP_L) && ((p_q == 4'd0) || (p_q > MAX_DIM_L))) begin
            chk_err_s = 2'd2;
        end else if (end_s > ADDR_LIMIT) begin
            chk_err_s = 2'd2;
        end else begin
            chk_err_s = 2'd0;
        end
    end

    // Saturating RUN counter increment and timeout detect.
    always_comb begin
        cnt_inc_s = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
        timeout_s = (cnt_inc_s >= TIMEOUT_L);
    end

    // Next-state logic for the command FSM and its datapath.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        m_d      = m_q;
        n_d      = n_q;
        p_d      = p_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_c_d = addr_c_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        cycles_d = cycles_q;
        abort_d  = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d     = cmd_op;
                    m_d      = cmd_m;
                    n_d      = cmd_n;
                    p_d      = cmd_p;
                    addr_a_d = cmd_addr_a;
                    addr_b_d = cmd_addr_b;
                    addr_c_d = cmd_addr_c;
                    cnt_d    = 16'd0;
                    state_d  = ST_CHECK;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                cycles_d = 16'd0;
                abort_d  = 1'b0;
                err_d    = chk_err_s;
                if (chk_err_s != 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc_s;
                // Done takes priority over a timeout in the same cycle.
                if (done_sel_s) begin
                    err_d    = 2'd0;
                    cycles_d = cnt_inc_s;
                    state_d  = ST_RELEASE;
                end else if (timeout_s) begin
                    err_d    = 2'd3;
                    cycles_d = cnt_inc_s;
                    abort_d  = 1'b1;
                    state_d  = ST_RELEASE;
                end else begin
                    state_d  = ST_RUN;
                end
            end
            ST_RELEASE: begin
                // An aborted unit may never drop done, so do not wait for it.
                if (abort_q || !done_sel_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Start level for the next state: only the selected unit, only in RUN.
    always_comb begin
        if (state_d == ST_RUN) begin
            start_d = sel_s;
        end else begin
            start_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            m_q      <= 4'd0;
            n_q      <= 4'd0;
            p_q      <= 4'd0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            cnt_q    <= 16'd0;
            err_q    <= 2'd0;
            cycles_q <= 16'd0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            m_q      <= m_d;
            n_q      <= n_d;
            p_q      <= p_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
            abort_q  <= abort_d;
        end
    end

    // Registered control outputs decoded from the next state, so they are
    // glitch-free and all drop together on an asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            start_q      <= '0;
            resp_valid_q <= 1'b0;
            steer_q      <= 1'b0;
        end else begin
            ready_q      <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            start_q      <= start_d;
            resp_valid_q <= (state_d == ST_RESP);
            steer_q      <= (state_d == ST_RUN) || (state_d == ST_RELEASE);
        end
    end

    // Combinational AND-OR steering of the selected unit's bus onto the BRAM
    // port. There is no register here, so unit read latency is unchanged.
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            mem_rd_en   = mem_rd_en | (steer_q & sel_s[k] & unit_rd_en[k]);
            mem_wr_en   = mem_wr_en | (steer_q & sel_s[k] & unit_wr_en[k]);
            mem_rd_addr = mem_rd_addr |
                          ({ADDR_WIDTH{steer_q & sel_s[k]}} & unit_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
            mem_wr_addr = mem_wr_addr |
                          ({ADDR_WIDTH{steer_q & sel_s[k]}} & unit_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
            mem_wr_data = mem_wr_data |
                          ({ELEMENT_WIDTH{steer_q & sel_s[k]}} & unit_wr_data[k*ELEMENT_WIDTH +: ELEMENT_WIDTH]);
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign unit_start  = start_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = err_q;
    assign resp_cycles = cycles_q;
    assign op_m        = m_q;
    assign op_n        = n_q;
    assign op_p        = p_q;
    assign op_addr_a   = addr_a_q;
    assign op_addr_b   = addr_b_q;
    assign op_addr_c   = addr_c_q;

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for matrix_op_scheduler. Four behavioural operator units drive
// random memory requests and a programmable done latency / done hold. The
// expected error code, cycle count and per-cycle bus steering follow from the
// command rules, computed with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_matrix_op_scheduler;

    localparam int AW = 10;
    localparam int EW = 16;
    localparam int NU = 4;
    localparam int TO = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [3:0]        cmd_m, cmd_n, cmd_p;
    logic [AW-1:0]     cmd_addr_a, cmd_addr_b, cmd_addr_c;
    logic [3:0]        op_m, op_n, op_p;
    logic [AW-1:0]     op_addr_a, op_addr_b, op_addr_c;
    logic [NU-1:0]     unit_start;
    logic [NU-1:0]     unit_done;
    logic [NU-1:0]     unit_rd_en, unit_wr_en;
    logic [NU*AW-1:0]  unit_rd_addr, unit_wr_addr;
    logic [NU*EW-1:0]  unit_wr_data;
    logic              mem_rd_en, mem_wr_en;
    logic [AW-1:0]     mem_rd_addr, mem_wr_addr;
    logic [EW-1:0]     mem_wr_data;
    logic              busy;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_err;
    logic [15:0]       resp_cycles;

    int tests = 0;
    int fails = 0;

    // Unit model controls (written by the main sequence, read by the driver).
    int cur_op   = 0;
    int lat      = 0;   // 0 = never signals done
    int hold     = 0;   // extra cycles done stays high after start drops
    bit force_wr = 1'b0;

    // Unit model state (driver process only).
    int run_cnt   = 0;
    bit sel_done  = 1'b0;
    int hold_left = 0;

    matrix_op_scheduler #(
        .NUM_UNITS(NU), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW),
        .MAX_DIM(5), .MUL_OP(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_p(cmd_p),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_c(cmd_addr_c),
        .op_m(op_m), .op_n(op_n), .op_p(op_p),
        .op_addr_a(op_addr_a), .op_addr_b(op_addr_b), .op_addr_c(op_addr_c),
        .unit_start(unit_start), .unit_done(unit_done),
        .unit_rd_en(unit_rd_en), .unit_wr_en(unit_wr_en),
        .unit_rd_addr(unit_rd_addr), .unit_wr_addr(unit_wr_addr),
        .unit_wr_data(unit_wr_data),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_err(resp_err), .resp_cycles(resp_cycles)
    );

    always #5 clk = ~clk;

    // Operator unit models: random memory traffic on every unit, random done
    // noise on non-selected units, latency/hold behaviour on the selected one.
    always @(negedge clk) begin
        logic [NU-1:0] d;
        unit_rd_en   = 4'($urandom);
        unit_wr_en   = force_wr ? 4'hF : 4'($urandom);
        unit_rd_addr = 40'({$urandom, $urandom});
        unit_wr_addr = 40'({$urandom, $urandom});
        unit_wr_data = {$urandom, $urandom};
        if (cur_op < NU && unit_start[cur_op] === 1'b1) begin
            run_cnt   = run_cnt + 1;
            sel_done  = (lat != 0) && (run_cnt >= lat);
            hold_left = hold;
        end else begin
            run_cnt = 0;
            if (sel_done && hold_left > 0) hold_left = hold_left - 1;
            else sel_done = 1'b0;
        end
        d = 4'($urandom);
        if (cur_op < NU) d[cur_op] = sel_done;
        unit_done = d;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mem_obs();
        return {26'd0, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data};
    endfunction

    function automatic logic [63:0] mem_exp(input int op);
        return {26'd0, unit_rd_en[op], unit_wr_en[op], unit_rd_addr[op*AW +: AW],
                unit_wr_addr[op*AW +: AW], unit_wr_data[op*EW +: EW]};
    endfunction

    // Reference validation rules in integer arithmetic.
    function automatic int exp_err(input int op, input int m, input int n, input int p, input int ac);
        if (op >= NU) return 1;
        if (m == 0 || m > 5 || n == 0 || n > 5) return 2;
        if (op == 2 && (p == 0 || p > 5)) return 2;
        if (ac + m * n > (1 << AW)) return 2;
        return 0;
    endfunction

    // One full command from acceptance to response consumption.
    task automatic run_cmd(input int op, input int m, input int n, input int p, input int ac,
                           input int lat_i, input int hold_i, input int resp_wait, input bit early);
        int e, L, R, ee, ec, aa, ab;
        logic [41:0] exp_op;
        aa = int'($urandom_range(0, 1023));
        ab = int'($urandom_range(0, 1023));
        e  = exp_err(op, m, n, p, ac);
        L  = (e != 0) ? 0 : ((lat_i == 0) ? TO : lat_i);
        R  = (e != 0) ? 0 : ((lat_i == 0) ? 1 : hold_i + 1);
        ee = (e != 0) ? e : ((lat_i == 0) ? 3 : 0);
        ec = L;
        exp_op = {4'(m), 4'(n), 4'(p), 10'(aa), 10'(ab), 10'(ac)};
        chk("idle_ready", 64'(cmd_ready), 64'd1);
        cur_op = op; lat = lat_i; hold = hold_i;
        cmd_valid = 1'b1; cmd_op = 3'(op); cmd_m = 4'(m); cmd_n = 4'(n); cmd_p = 4'(p);
        cmd_addr_a = 10'(aa); cmd_addr_b = 10'(ab); cmd_addr_c = 10'(ac);
        step();
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_m = 4'($urandom); cmd_n = 4'($urandom);
        cmd_p = 4'($urandom); cmd_addr_c = 10'($urandom);
        chk("check_ready", 64'(cmd_ready), 64'd0);
        chk("check_busy", 64'(busy), 64'd1);
        chk("check_start", 64'(unit_start), 64'd0);
        chk("check_mem", mem_obs(), 64'd0);
        chk("op_latch", 64'({op_m, op_n, op_p, op_addr_a, op_addr_b, op_addr_c}), 64'(exp_op));
        for (int i = 0; i < L; i++) begin
            step();
            chk("run_start", 64'(unit_start), 64'(4'b0001 << op));
            chk("run_mem", mem_obs(), mem_exp(op));
        end
        for (int i = 0; i < R; i++) begin
            step();
            chk("rel_start", 64'(unit_start), 64'd0);
            chk("rel_mem", mem_obs(), mem_exp(op));
        end
        step();
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("resp_err", 64'(resp_err), 64'(ee));
        chk("resp_cycles", 64'(resp_cycles), 64'(ec));
        chk("resp_start", 64'(unit_start), 64'd0);
        chk("resp_mem", mem_obs(), 64'd0);
        chk("op_hold", 64'({op_m, op_n, op_p, op_addr_a, op_addr_b, op_addr_c}), 64'(exp_op));
        for (int w = 0; w < resp_wait; w++) begin
            step();
            chk("wait_valid", 64'({resp_valid, resp_err, resp_cycles}), 64'({1'b1, 2'(ee), 16'(ec)}));
            chk("wait_ready", 64'(cmd_ready), 64'd0);
        end
        resp_ready = 1'b1;
        if (early) begin
            cmd_valid = 1'b1; cmd_op = 3'd1; cmd_m = 4'(m + 1); cmd_n = 4'd1; cmd_p = 4'd1;
            cmd_addr_c = 10'd0;
        end
        step();
        resp_ready = 1'b0;
        cmd_valid  = 1'b0;
        chk("idle_valid", 64'(resp_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready2", 64'(cmd_ready), 64'd1);
        chk("idle_keep", 64'({resp_err, resp_cycles}), 64'({2'(ee), 16'(ec)}));
        if (early) chk("early_reject", 64'(op_m), 64'(m));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; resp_ready = 1'b0;
        cmd_op = 3'd0; cmd_m = 4'd0; cmd_n = 4'd0; cmd_p = 4'd0;
        cmd_addr_a = 10'd0; cmd_addr_b = 10'd0; cmd_addr_c = 10'd0;
        #23;
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_ctrl", 64'({busy, unit_start, resp_valid, resp_err, resp_cycles}), 64'd0);
        chk("rst_op", 64'({op_m, op_n, op_p, op_addr_a, op_addr_b, op_addr_c}), 64'd0);
        chk("rst_mem", mem_obs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Mul command with a 50-cycle unit.
        run_cmd(2, 2, 3, 2, 12'h040, 50, 0, 0, 1'b0);
        // Validation errors.
        run_cmd(5, 2, 2, 2, 0, 5, 0, 1, 1'b0);
        run_cmd(0, 0, 2, 2, 0, 5, 0, 0, 1'b0);
        run_cmd(1, 2, 6, 2, 0, 5, 0, 0, 1'b0);
        run_cmd(2, 2, 2, 0, 0, 5, 0, 0, 1'b0);
        run_cmd(1, 3, 3, 0, 100, 4, 0, 0, 1'b0);
        // Result range boundary.
        run_cmd(3, 2, 2, 1, (1 << AW) - 4, 3, 0, 0, 1'b0);
        run_cmd(3, 2, 2, 1, (1 << AW) - 3, 3, 0, 0, 1'b0);
        // Timeout, then a normal command.
        run_cmd(3, 1, 1, 1, 0, 0, 0, 0, 1'b0);
        run_cmd(0, 5, 5, 5, 999, 7, 0, 0, 1'b0);
        // Response back-pressure and early command.
        run_cmd(1, 3, 2, 1, 10, 6, 0, 10, 1'b1);
        // Done held high after start drops.
        run_cmd(0, 4, 4, 0, 200, 5, 3, 0, 1'b0);
        run_cmd(2, 1, 5, 5, 0, 1, 2, 0, 1'b0);

        // Randomized commands.
        for (int i = 0; i < 25; i++) begin
            int op, m, n, p, ac;
            op = int'($urandom_range(0, 4));
            m  = int'($urandom_range(0, 6));
            n  = int'($urandom_range(0, 6));
            p  = int'($urandom_range(0, 6));
            ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(995, 1023)) : int'($urandom_range(0, 1023));
            run_cmd(op, m, n, p, ac, int'($urandom_range(1, 20)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset pulsed in the middle of RUN.
        cur_op = 1; lat = 0; hold = 0; force_wr = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_m = 4'd2; cmd_n = 4'd2; cmd_p = 4'd2;
        cmd_addr_c = 10'd0;
        step();
        cmd_valid = 1'b0;
        repeat (20) step();
        chk("mid_run_start", 64'(unit_start), 64'd2);
        chk("mid_run_wr", 64'(mem_wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_start", 64'(unit_start), 64'd0);
        chk("arst_wr", 64'(mem_wr_en), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(cmd_ready), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        force_wr = 1'b0;
        step();
        chk("arst_release_ready", 64'(cmd_ready), 64'd1);
        run_cmd(2, 3, 3, 3, 300, 9, 1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
